rv32_mtimer: RTL and testbench
==============================

RV32_MTIMER -- requirements
Module: rv32_mtimer

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8, meaning the width of the prescaler divide field and counter.
REQ-002 SHALL have parameter RESET_MTIMECMP, default 64'hFFFF_FFFF_FFFF_FFFF, meaning the mtimecmp value loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sel, input, 1 bit: address decode select from the LSU bus.
REQ-006 SHALL have port addr, input, 5 bits: byte offset; only addr[4:2] is decoded.
REQ-007 SHALL have port rready, input, 1 bit: read request from the core LSU.
REQ-008 SHALL have port rvalid, output, 1 bit: read data valid, single-cycle pulse.
REQ-009 SHALL have port wvalid, input, 1 bit: write request from the core LSU.
REQ-010 SHALL have port wready, output, 1 bit: write accepted, single-cycle pulse.
REQ-011 SHALL have port strb, input, 4 bits: byte write strobes.
REQ-012 SHALL have port wdata, input, 32 bits: write data.
REQ-013 SHALL have port rdata, output, 32 bits: registered read data.
REQ-014 SHALL have port timer_irq, output, 1 bit: machine timer interrupt level to the core.

Function
REQ-015 SHALL map registers as follows: 0x00 mtime[31:0], 0x04 mtime[63:32], 0x08 mtimecmp[31:0], 0x0C mtimecmp[63:32], 0x10 CTRL (bit0 EN, bits[8+DIV_WIDTH-1:8] DIV, other bits read 0); all other offsets are unmapped.
REQ-016 SHALL accept a write in cycle N when sel&wvalid&!wready, update the target register at the end of cycle N, and drive wready=1 for exactly cycle N+1.
REQ-017 SHALL accept a read in cycle N when sel&rready&!rvalid&!(write accepted in N), latch rdata at the end of N, and drive rvalid=1 for exactly cycle N+1; rdata holds until the next accepted read.
REQ-018 SHALL give a write priority when read and write are requested in the same cycle; the read is accepted no earlier than the following eligible cycle.
REQ-019 SHALL apply writes per byte: byte k is updated only when strb[k]=1; strb=0 still completes the handshake without changing state.
REQ-020 SHALL return 0 on reads of unmapped offsets and ignore writes to them, with normal handshake timing.
REQ-021 SHALL run the prescaler counter only while EN=1; when counter==DIV it shall clear to 0 and emit one tick, otherwise increment; DIV=0 shall produce a tick every cycle.
REQ-022 SHALL increment mtime by 1 on each tick, with 64-bit modulo wrap (FFFF_FFFF_FFFF_FFFF -> 0, carry propagated from low to high word in the same cycle).
REQ-023 SHALL let a write to either mtime word take precedence over a tick in the same cycle: the written bytes take wdata, the unwritten bytes keep their current value, and no increment occurs that cycle.
REQ-024 SHALL hold the prescaler at 0 when EN is cleared, with mtime frozen; setting EN shall restart counting from 0.
REQ-025 SHALL register timer_irq as (mtime >= mtimecmp), 64-bit unsigned, evaluated on current register values; timer_irq therefore lags any change by one cycle.
REQ-026 SHALL return the pre-update value on a read that is accepted in the same cycle as a tick (read sees mtime before the increment).
REQ-027 SHALL keep timer_irq a level; it deasserts only through a write of mtimecmp or mtime that makes mtime < mtimecmp.

Reset
REQ-028 SHALL on rst_n=0, asynchronously and regardless of any transaction in flight, set mtime=0, mtimecmp=RESET_MTIMECMP, CTRL=0 (EN=0, DIV=0), prescaler=0, rvalid=0, wready=0, rdata=0, timer_irq=0.
REQ-029 SHALL drop any transaction accepted before reset without producing a response after reset release.

Verification
REQ-030 Write 0x10 wdata=0x0000_0301 strb=0xF, then run 16 cycles -> wready pulses for 1 cycle after acceptance; mtime advances by 1 every 4 cycles, reaching 4.
REQ-031 Write mtime lo=0xFFFF_FFFF, hi=0xFFFF_FFFF, EN=1, DIV=0 -> after 1 tick mtime=0 in both words; read of 0x04 returns 0.
REQ-032 Set mtimecmp=5 (hi=0), EN=1, DIV=0 from mtime=0 -> timer_irq rises 1 cycle after mtime reaches 5; writing mtimecmp hi=1 drops it the cycle after the write.
REQ-033 Assert rready and wvalid together at 0x08 -> write completes first (wready at N+1), read then returns the newly written value with rvalid one cycle after its acceptance.
REQ-034 Write 0x00 wdata=0xAABB_CCDD strb=0x3 over mtime lo=0x1122_3344 in a tick cycle -> mtime lo=0x1122_CCDD with no increment; read of 0x14 returns 0 with normal rvalid.
REQ-035 Pull rst_n low in the cycle after a read is accepted -> rvalid stays 0, and all registers hold their REQ-028 values after release.

Source files
------------

// File: rtl/rv32_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp, an enable/prescaler control
// register and a single-beat LSU read/write port with registered responses.
module rv32_mtimer #(
  parameter int          DIV_WIDTH      = 8,
  parameter logic [63:0] RESET_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [4:0]  addr,
  input  logic        rready,
  output logic        rvalid,
  input  logic        wvalid,
  output logic        wready,
  input  logic [3:0]  strb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_irq
);

  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;

  logic [31:0]          mtime_lo_reg, mtime_lo_next;
  logic [31:0]          mtime_hi_reg, mtime_hi_next;
  logic [31:0]          cmp_lo_reg, cmp_lo_next;
  logic [31:0]          cmp_hi_reg, cmp_hi_next;
  logic                 en_reg, en_next;
  logic [DIV_WIDTH-1:0] div_reg, div_next;
  logic [DIV_WIDTH-1:0] presc_reg, presc_next;
  logic                 rvalid_reg, wready_reg, irq_reg, irq_next;
  logic [31:0]          rdata_reg, rdata_next;

  logic        wr_acc, rd_acc;
  logic [2:0]  idx;
  logic [31:0] wmask;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic        tick;
  logic [63:0] mtime_inc;
  logic [31:0] ctrl_word;
  logic        unused_addr;

  assign idx         = addr[4:2];
  assign unused_addr = &{1'b0, addr[1:0]};

  // A write blocks a simultaneous read; the read retries next cycle.
  assign wr_acc = sel & wvalid & ~wready_reg;
  assign rd_acc = sel & rready & ~rvalid_reg & ~wr_acc;

  assign wr_mtime_lo = wr_acc && (idx == IDX_MTIME_LO);
  assign wr_mtime_hi = wr_acc && (idx == IDX_MTIME_HI);
  assign wr_cmp_lo   = wr_acc && (idx == IDX_CMP_LO);
  assign wr_cmp_hi   = wr_acc && (idx == IDX_CMP_HI);
  assign wr_ctrl     = wr_acc && (idx == IDX_CTRL);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{strb[gi]}};
    end
  endgenerate

  assign tick      = en_reg && (presc_reg == div_reg);
  assign mtime_inc = {mtime_hi_reg, mtime_lo_reg} + 64'd1;
  assign ctrl_word = (32'(div_reg) << 8) | 32'(en_reg);

  // DIV occupies bits [8 +: DIV_WIDTH]; each bit follows its byte strobe.
  assign en_next = (wr_ctrl && strb[0]) ? wdata[0] : en_reg;
  generate
    for (gi = 0; gi < DIV_WIDTH; gi++) begin : g_div
      assign div_next[gi] = (wr_ctrl && wmask[8+gi]) ? wdata[8+gi] : div_reg[gi];
    end
  endgenerate

  always_comb begin
    presc_next = '0;
    if (en_reg && en_next && !tick) begin
      presc_next = presc_reg + DIV_WIDTH'(1);
    end
  end

  // A bus write to either mtime word suppresses that cycle's increment.
  always_comb begin
    mtime_lo_next = mtime_lo_reg;
    mtime_hi_next = mtime_hi_reg;
    if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) begin
        mtime_lo_next = (mtime_lo_reg & ~wmask) | (wdata & wmask);
      end
      if (wr_mtime_hi) begin
        mtime_hi_next = (mtime_hi_reg & ~wmask) | (wdata & wmask);
      end
    end else if (tick) begin
      mtime_lo_next = mtime_inc[31:0];
      mtime_hi_next = mtime_inc[63:32];
    end
  end

  always_comb begin
    cmp_lo_next = cmp_lo_reg;
    cmp_hi_next = cmp_hi_reg;
    if (wr_cmp_lo) begin
      cmp_lo_next = (cmp_lo_reg & ~wmask) | (wdata & wmask);
    end
    if (wr_cmp_hi) begin
      cmp_hi_next = (cmp_hi_reg & ~wmask) | (wdata & wmask);
    end
  end

  assign irq_next = ({mtime_hi_reg, mtime_lo_reg} >= {cmp_hi_reg, cmp_lo_reg});

  // Read data reflects register state before this cycle's update.
  always_comb begin
    rdata_next = rdata_reg;
    if (rd_acc) begin
      case (idx)
        IDX_MTIME_LO: rdata_next = mtime_lo_reg;
        IDX_MTIME_HI: rdata_next = mtime_hi_reg;
        IDX_CMP_LO:   rdata_next = cmp_lo_reg;
        IDX_CMP_HI:   rdata_next = cmp_hi_reg;
        IDX_CTRL:     rdata_next = ctrl_word;
        default:      rdata_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_lo_reg <= 32'd0;
      mtime_hi_reg <= 32'd0;
      cmp_lo_reg   <= RESET_MTIMECMP[31:0];
      cmp_hi_reg   <= RESET_MTIMECMP[63:32];
      en_reg       <= 1'b0;
      div_reg      <= '0;
      presc_reg    <= '0;
      rvalid_reg   <= 1'b0;
      wready_reg   <= 1'b0;
      rdata_reg    <= 32'd0;
      irq_reg      <= 1'b0;
    end else begin
      mtime_lo_reg <= mtime_lo_next;
      mtime_hi_reg <= mtime_hi_next;
      cmp_lo_reg   <= cmp_lo_next;
      cmp_hi_reg   <= cmp_hi_next;
      en_reg       <= en_next;
      div_reg      <= div_next;
      presc_reg    <= presc_next;
      rvalid_reg   <= rd_acc;
      wready_reg   <= wr_acc;
      rdata_reg    <= rdata_next;
      irq_reg      <= irq_next;
    end
  end

  assign rvalid    = rvalid_reg;
  assign wready    = wready_reg;
  assign rdata     = rdata_reg;
  assign timer_irq = irq_reg;

endmodule

// File: tb/tb_rv32_mtimer.sv
// Self-checking bench for rv32_mtimer: read expectations are queued when a
// read is driven and compared when rvalid appears.
module tb_rv32_mtimer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [4:0]  addr;
  logic        rready;
  logic        rvalid;
  logic        wvalid;
  logic        wready;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  rv32_mtimer #(.DIV_WIDTH(8), .RESET_MTIMECMP(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .rready(rready),
    .rvalid(rvalid), .wvalid(wvalid), .wready(wready), .strb(strb),
    .wdata(wdata), .rdata(rdata), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every rvalid beat must match the oldest queued read.
  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      if (sb_q.size() == 0) begin
        check_eq("rvalid_unexpected", 64'(rvalid), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq(e.tag, 64'(rdata), 64'(e.exp));
        $display("rd %s data=0x%08h exp=0x%08h", e.tag, rdata, e.exp);
      end
    end
  end

  task automatic push_exp(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    sel = 1'b1; addr = a; wdata = d; strb = s; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0; sel = 1'b0;
    check_eq($sformatf("wready_hi_%02h", a), 64'(wready), 64'd1);
    @(posedge clk); #1;
    check_eq($sformatf("wready_lo_%02h", a), 64'(wready), 64'd0);
    $display("wr addr=0x%02h data=0x%08h strb=0x%h", a, d, s);
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
    sel = 1'b1; addr = a; rready = 1'b1;
    push_exp(tag, exp);
    @(posedge clk); #1;
    rready = 1'b0; sel = 1'b0;
    check_eq({tag, "_rvalid_hi"}, 64'(rvalid), 64'd1);
    @(posedge clk); #1;
    check_eq({tag, "_rvalid_lo"}, 64'(rvalid), 64'd0);
  endtask

  // Read and write requested together: write first, read one cycle later.
  task automatic wr_rd(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp, input string tag);
    sel = 1'b1; addr = a; wdata = d; strb = s; wvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check_eq({tag, "_wready_hi"}, 64'(wready), 64'd1);
    check_eq({tag, "_rvalid_wait"}, 64'(rvalid), 64'd0);
    push_exp(tag, exp);
    @(posedge clk); #1;
    rready = 1'b0; sel = 1'b0;
    check_eq({tag, "_wready_lo"}, 64'(wready), 64'd0);
    check_eq({tag, "_rvalid_hi"}, 64'(rvalid), 64'd1);
    @(posedge clk); #1;
    check_eq({tag, "_rvalid_lo"}, 64'(rvalid), 64'd0);
    $display("wr+rd addr=0x%02h data=0x%08h strb=0x%h", a, d, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; addr = '0; rready = 1'b0; wvalid = 1'b0;
    strb = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rvalid", 64'(rvalid), 64'd0);
    check_eq("rst_wready", 64'(wready), 64'd0);
    check_eq("rst_irq", 64'(timer_irq), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    bus_read(5'h00, 32'h0, "rst_mtime_lo");
    bus_read(5'h04, 32'h0, "rst_mtime_hi");
    bus_read(5'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
    bus_read(5'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    bus_read(5'h10, 32'h0, "rst_ctrl");

    // EN=1, DIV=3: one tick every 4 cycles.
    bus_write(5'h10, 32'h0000_0301, 4'hF);
    repeat (6) @(posedge clk);
    #1;
    bus_read(5'h00, 32'h1, "div3_tick_cycle_pre");
    repeat (6) @(posedge clk);
    #1;
    bus_write(5'h10, 32'h0, 4'h1);
    bus_read(5'h00, 32'h4, "div3_mtime_lo");
    bus_read(5'h04, 32'h0, "div3_mtime_hi");
    bus_read(5'h10, 32'h0000_0300, "ctrl_div_kept");

    bus_write(5'h10, 32'hFFFF_FFFF, 4'hF);
    bus_read(5'h10, 32'h0000_FF01, "ctrl_unused_zero");
    bus_write(5'h10, 32'h0, 4'hF);

    bus_write(5'h08, 32'hDEAD_BEEF, 4'h0);
    bus_read(5'h08, 32'hFFFF_FFFF, "strb0_no_change");
    bus_write(5'h14, 32'h1234_5678, 4'hF);
    bus_read(5'h14, 32'h0, "unmapped_14");
    bus_read(5'h18, 32'h0, "unmapped_18");
    bus_read(5'h1C, 32'h0, "unmapped_1c");

    // 64-bit wrap.
    bus_write(5'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(5'h04, 32'hFFFF_FFFF, 4'hF);
    bus_read(5'h04, 32'hFFFF_FFFF, "allones_hi");
    check_eq("irq_allones", 64'(timer_irq), 64'd1);
    bus_write(5'h10, 32'h1, 4'hF);
    bus_read(5'h00, 32'h0, "wrap_lo");
    bus_read(5'h04, 32'h0, "wrap_hi");
    bus_write(5'h10, 32'h0, 4'hF);

    // Compare match and deassert through mtimecmp hi.
    bus_write(5'h00, 32'h0, 4'hF);
    bus_write(5'h04, 32'h0, 4'hF);
    bus_write(5'h08, 32'h5, 4'hF);
    bus_write(5'h0C, 32'h0, 4'hF);
    check_eq("irq_below_cmp", 64'(timer_irq), 64'd0);
    bus_write(5'h10, 32'h1, 4'hF);
    repeat (4) @(posedge clk);
    #1;
    check_eq("irq_lag_at_5", 64'(timer_irq), 64'd0);
    @(posedge clk); #1;
    check_eq("irq_rise", 64'(timer_irq), 64'd1);
    bus_write(5'h0C, 32'h1, 4'hF);
    check_eq("irq_drop", 64'(timer_irq), 64'd0);
    bus_write(5'h10, 32'h0, 4'hF);

    wr_rd(5'h08, 32'h1234_5678, 4'hF, 32'h1234_5678, "wr_prio_cmp_lo");

    // Partial mtime write colliding with a tick.
    bus_write(5'h00, 32'h1122_3344, 4'hF);
    bus_write(5'h04, 32'h0, 4'hF);
    bus_write(5'h10, 32'h1, 4'hF);
    wr_rd(5'h00, 32'hAABB_CCDD, 4'h3, 32'h1122_CCDD, "tick_vs_write");
    bus_write(5'h10, 32'h0, 4'hF);
    bus_read(5'h14, 32'h0, "unmapped_14_again");

    // Reset while a read response is on the bus.
    bus_write(5'h10, 32'h0000_0500, 4'hF);
    sel = 1'b1; addr = 5'h08; rready = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; rready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_rvalid", 64'(rvalid), 64'd0);
    check_eq("rstmid_rdata", 64'(rdata), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("post_rst_rvalid_%0d", i), 64'(rvalid), 64'd0);
      check_eq($sformatf("post_rst_wready_%0d", i), 64'(wready), 64'd0);
    end
    check_eq("post_rst_rdata", 64'(rdata), 64'd0);
    check_eq("post_rst_irq", 64'(timer_irq), 64'd0);
    bus_read(5'h00, 32'h0, "post_rst_mtime_lo");
    bus_read(5'h04, 32'h0, "post_rst_mtime_hi");
    bus_read(5'h08, 32'hFFFF_FFFF, "post_rst_cmp_lo");
    bus_read(5'h0C, 32'hFFFF_FFFF, "post_rst_cmp_hi");
    bus_read(5'h10, 32'h0, "post_rst_ctrl");

    repeat (2) @(posedge clk);
    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
